// File: rtl/canvas_painter_if.sv
// Cursor/button/clear inputs and canvas/status outputs of the canvas painter.
// The master side drives stimulus; the slave side is the painter itself.
interface canvas_painter_if #(
   parameter int unsigned N = 28
);
   logic                        frame_tick;
   logic [9:0]                  BallX;
   logic [9:0]                  BallY;
   logic                        draw_btn;
   logic                        erase_btn;
   logic                        clear_req;
   logic [N-1:0][N-1:0][15:0]   canvas;
   logic                        busy;
   logic                        clear_done;

   modport master (
      output frame_tick, BallX, BallY, draw_btn, erase_btn, clear_req,
      input  canvas, busy, clear_done
   );

   modport slave (
      input  frame_tick, BallX, BallY, draw_btn, erase_btn, clear_req,
      output canvas, busy, clear_done
   );
endinterface

// File: rtl/canvas_painter.sv
// 28x28 drawing canvas: once per frame paints or erases a plus-shaped brush
// under the cursor, one cell per cycle, and runs a column-by-column clear.
module canvas_painter #(
   parameter int unsigned ORIGIN_X = 199,
   parameter int unsigned ORIGIN_Y = 43,
   parameter int unsigned CELL     = 14,
   parameter int unsigned N        = 28,
   parameter logic [15:0] INC      = 16'h0300,
   parameter logic [15:0] NBR_INC  = 16'h0180,
   parameter logic [15:0] MAXV     = 16'h07FF
) (
   input  logic          Clk,
   input  logic          Reset,
   canvas_painter_if.slave bus
);

   localparam int unsigned CW    = $clog2(N);
   localparam int unsigned X_END = ORIGIN_X + N * CELL;
   localparam int unsigned Y_END = ORIGIN_Y + N * CELL;
   localparam logic [CW:0] ONE   = 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CLEAR  = 2'd1;
   localparam logic [1:0] S_LATCH  = 2'd2;
   localparam logic [1:0] S_STROKE = 2'd3;

   logic [1:0]                r_state, w_state_nxt;
   logic [CW-1:0]             r_col, w_col_nxt;
   logic [2:0]                r_step, w_step_nxt;
   logic [CW-1:0]             r_cx, r_cy;
   logic                      r_erase;
   logic                      r_busy, r_clear_done, w_clear_done_nxt;
   logic [N-1:0][N-1:0][15:0] r_canvas;

   logic          w_on_x, w_on_y, w_on;
   logic [9:0]    w_dx, w_dy;
   logic [CW-1:0] w_cx, w_cy;
   logic [CW:0]   w_tx, w_ty;
   logic [15:0]   w_amt, w_cell, w_new;
   logic [16:0]   w_sum;
   logic          w_tgt_ok;

   // Screen position to cell coordinates
   assign w_on_x = (32'(bus.BallX) >= ORIGIN_X) && (32'(bus.BallX) < X_END);
   assign w_on_y = (32'(bus.BallY) >= ORIGIN_Y) && (32'(bus.BallY) < Y_END);
   assign w_on   = w_on_x && w_on_y;
   assign w_dx   = bus.BallX - 10'(ORIGIN_X);
   assign w_dy   = bus.BallY - 10'(ORIGIN_Y);
   assign w_cx   = CW'(w_dx / 10'(CELL));
   assign w_cy   = CW'(w_dy / 10'(CELL));

   // Brush target for this stroke step; one extra bit flags under/overflow
   always_comb begin
      w_tx  = {1'b0, r_cx};
      w_ty  = {1'b0, r_cy};
      w_amt = NBR_INC;
      case (r_step)
         3'd0:    w_amt = INC;
         3'd1:    w_ty  = {1'b0, r_cy} - ONE;
         3'd2:    w_ty  = {1'b0, r_cy} + ONE;
         3'd3:    w_tx  = {1'b0, r_cx} - ONE;
         3'd4:    w_tx  = {1'b0, r_cx} + ONE;
         default: ;
      endcase
   end

   assign w_tgt_ok = (32'(w_tx) < N) && (32'(w_ty) < N);
   assign w_cell   = r_canvas[w_tx[CW-1:0]][w_ty[CW-1:0]];
   assign w_sum    = {1'b0, w_cell} + {1'b0, w_amt};

   // Saturating paint / floored erase
   always_comb begin
      if (r_erase) w_new = (w_cell < w_amt) ? 16'h0000 : (w_cell - w_amt);
      else         w_new = (w_sum > {1'b0, MAXV}) ? MAXV : w_sum[15:0];
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_col_nxt        = r_col;
      w_step_nxt       = r_step;
      w_clear_done_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.clear_req) begin
               w_state_nxt = S_CLEAR;
               w_col_nxt   = '0;
            end else if (bus.frame_tick && (bus.draw_btn || bus.erase_btn) && w_on) begin
               w_state_nxt = S_LATCH;
            end
         end
         S_CLEAR: begin
            w_col_nxt = r_col + CW'(1);
            if (r_col == CW'(N - 1)) begin
               w_state_nxt      = S_IDLE;
               w_col_nxt        = '0;
               w_clear_done_nxt = 1'b1;
            end
         end
         S_LATCH: begin
            w_step_nxt  = 3'd0;
            w_state_nxt = S_STROKE;
         end
         S_STROKE: begin
            w_step_nxt = r_step + 3'd1;
            if (r_step == 3'd4) begin
               w_state_nxt = S_IDLE;
               w_step_nxt  = 3'd0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state      <= S_IDLE;
         r_col        <= '0;
         r_step       <= '0;
         r_cx         <= '0;
         r_cy         <= '0;
         r_erase      <= 1'b0;
         r_busy       <= 1'b0;
         r_clear_done <= 1'b0;
         r_canvas     <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_col        <= w_col_nxt;
         r_step       <= w_step_nxt;
         r_busy       <= (w_state_nxt != S_IDLE);
         r_clear_done <= w_clear_done_nxt;
         if (r_state == S_LATCH) begin
            r_cx    <= w_cx;
            r_cy    <= w_cy;
            r_erase <= bus.erase_btn;
         end
         if (r_state == S_CLEAR)
            r_canvas[r_col] <= '0;
         else if (r_state == S_STROKE && w_tgt_ok)
            r_canvas[w_tx[CW-1:0]][w_ty[CW-1:0]] <= w_new;
      end
   end

   assign bus.canvas     = r_canvas;
   assign bus.busy       = r_busy;
   assign bus.clear_done = r_clear_done;

endmodule

// File: tb/tb_canvas_painter.sv
// Directed bench for canvas_painter: paint, saturate, erase, clip, clear
// and reset-abort scenarios against hand-computed cell values.
module tb_canvas_painter;

   logic clk;
   logic rst;

   canvas_painter_if #(.N(28)) bus ();

   canvas_painter dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [15:0] exp_c [28][28];
   int          nb, nd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   function automatic int count_mism();
      int m = 0;
      for (int x = 0; x < 28; x++)
         for (int y = 0; y < 28; y++)
            if (bus.canvas[x][y] !== exp_c[x][y]) m++;
      return m;
   endfunction

   task automatic exp_zero();
      for (int x = 0; x < 28; x++)
         for (int y = 0; y < 28; y++)
            exp_c[x][y] = 16'h0000;
   endtask

   // Pulse tick/clear for one cycle, then watch 40 cycles of busy/clear_done
   task automatic go(input logic ft, input logic cr, output int nbusy, output int ndone);
      bus.frame_tick = ft;
      bus.clear_req  = cr;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      bus.clear_req  = 1'b0;
      nbusy = 0;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.busy === 1'b1) nbusy++;
         if (bus.clear_done === 1'b1) ndone++;
         @(negedge clk);
      end
   endtask

   task automatic set_in(input int x, input int y, input logic d, input logic e);
      bus.BallX     = 10'(x);
      bus.BallY     = 10'(y);
      bus.draw_btn  = d;
      bus.erase_btn = e;
   endtask

   initial begin
      rst            = 1'b1;
      bus.frame_tick = 1'b0;
      bus.clear_req  = 1'b0;
      set_in(0, 0, 1'b0, 1'b0);
      exp_zero();
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset then idle
      nb = 0; nd = 0;
      for (int k = 0; k < 100; k++) begin
         if (bus.busy === 1'b1) nb++;
         if (bus.clear_done === 1'b1) nd++;
         @(negedge clk);
      end
      chk("idle_busy", 32'(nb), 32'd0);
      chk("idle_done", 32'(nd), 32'd0);
      chk("idle_canvas", 32'(count_mism()), 32'd0);

      // Single draw at cell (10,5)
      set_in(344, 116, 1'b1, 1'b0);
      go(1'b1, 1'b0, nb, nd);
      exp_c[10][5] = 16'h0300;
      exp_c[10][4] = 16'h0180; exp_c[10][6] = 16'h0180;
      exp_c[9][5]  = 16'h0180; exp_c[11][5] = 16'h0180;
      chk("draw1_busy", 32'(nb), 32'd6);
      chk("draw1_done", 32'(nd), 32'd0);
      chk("draw1_centre", 32'(bus.canvas[10][5]), 32'h0300);
      chk("draw1_canvas", 32'(count_mism()), 32'd0);

      // Two more draws: centre saturates
      go(1'b1, 1'b0, nb, nd);
      go(1'b1, 1'b0, nb, nd);
      exp_c[10][5] = 16'h07FF;
      exp_c[10][4] = 16'h0480; exp_c[10][6] = 16'h0480;
      exp_c[9][5]  = 16'h0480; exp_c[11][5] = 16'h0480;
      chk("sat_centre", 32'(bus.canvas[10][5]), 32'h07FF);
      chk("sat_canvas", 32'(count_mism()), 32'd0);

      // Erase with both buttons held: erase wins
      set_in(344, 116, 1'b1, 1'b1);
      go(1'b1, 1'b0, nb, nd);
      exp_c[10][5] = 16'h04FF;
      exp_c[10][4] = 16'h0300; exp_c[10][6] = 16'h0300;
      exp_c[9][5]  = 16'h0300; exp_c[11][5] = 16'h0300;
      chk("erase_centre", 32'(bus.canvas[10][5]), 32'h04FF);
      chk("erase_canvas", 32'(count_mism()), 32'd0);

      // Further erases floor at zero
      set_in(344, 116, 1'b0, 1'b1);
      repeat (6) go(1'b1, 1'b0, nb, nd);
      exp_zero();
      chk("floor_centre", 32'(bus.canvas[10][5]), 32'h0000);
      chk("floor_canvas", 32'(count_mism()), 32'd0);

      // Top-left corner clips without wrapping
      set_in(199, 43, 1'b1, 1'b0);
      go(1'b1, 1'b0, nb, nd);
      exp_c[0][0] = 16'h0300;
      exp_c[1][0] = 16'h0180; exp_c[0][1] = 16'h0180;
      chk("clip_busy", 32'(nb), 32'd6);
      chk("clip_x27", 32'(bus.canvas[27][0]), 32'h0000);
      chk("clip_y27", 32'(bus.canvas[0][27]), 32'h0000);
      chk("clip_canvas", 32'(count_mism()), 32'd0);

      // Off-canvas cursor on both sides
      set_in(198, 43, 1'b1, 1'b0);
      go(1'b1, 1'b0, nb, nd);
      chk("off_left_busy", 32'(nb), 32'd0);
      chk("off_left_canvas", 32'(count_mism()), 32'd0);
      set_in(591, 43, 1'b1, 1'b0);
      go(1'b1, 1'b0, nb, nd);
      chk("off_right_busy", 32'(nb), 32'd0);
      chk("off_right_canvas", 32'(count_mism()), 32'd0);

      // Second tick during STROKE is ignored
      set_in(344, 116, 1'b1, 1'b0);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      nb = 0;
      for (int k = 0; k < 30; k++) begin
         if (bus.busy === 1'b1) nb++;
         bus.frame_tick = (k == 1);
         @(negedge clk);
      end
      bus.frame_tick = 1'b0;
      exp_c[10][5] = 16'h0300;
      exp_c[10][4] = 16'h0180; exp_c[10][6] = 16'h0180;
      exp_c[9][5]  = 16'h0180; exp_c[11][5] = 16'h0180;
      chk("dbl_tick_busy", 32'(nb), 32'd6);
      chk("dbl_tick_canvas", 32'(count_mism()), 32'd0);

      // Clear after painting
      set_in(0, 0, 1'b0, 1'b0);
      go(1'b0, 1'b1, nb, nd);
      exp_zero();
      chk("clear_busy", 32'(nb), 32'd28);
      chk("clear_done", 32'(nd), 32'd1);
      chk("clear_canvas", 32'(count_mism()), 32'd0);

      // Clear beats a same-cycle paint tick
      set_in(344, 116, 1'b1, 1'b0);
      go(1'b1, 1'b0, nb, nd);
      chk("repaint_centre", 32'(bus.canvas[10][5]), 32'h0300);
      go(1'b1, 1'b1, nb, nd);
      chk("prio_busy", 32'(nb), 32'd28);
      chk("prio_done", 32'(nd), 32'd1);
      chk("prio_canvas", 32'(count_mism()), 32'd0);

      // Reset at stroke step 2 aborts immediately
      set_in(344, 116, 1'b1, 1'b0);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_partial", 32'(bus.canvas[10][5]), 32'h0300);
      chk("abort_busy_pre", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_canvas", 32'(count_mism()), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      set_in(344, 116, 1'b1, 1'b0);
      go(1'b1, 1'b0, nb, nd);
      exp_c[10][5] = 16'h0300;
      exp_c[10][4] = 16'h0180; exp_c[10][6] = 16'h0180;
      exp_c[9][5]  = 16'h0180; exp_c[11][5] = 16'h0180;
      chk("post_reset_busy", 32'(nb), 32'd6);
      chk("post_reset_canvas", 32'(count_mism()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
